// File: rtl/seg_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one SEG_W segment per stage; latency NSEG accepted-to-valid.
// Backpressure: all stages advance together only when the output is empty or being consumed.
module seg_pipe_adder #(
    parameter int SEG_W = 8,
    parameter int NSEG  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEG_W*NSEG-1:0]    a,
    input  logic [SEG_W*NSEG-1:0]    b,
    input  logic                     c0,
    input  logic                     sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEG_W*NSEG-1:0]    s,
    output logic                     cout,
    output logic                     sx,
    output logic                     zero
);
    localparam int WIDTH = SEG_W * NSEG;
    localparam int LAST  = NSEG - 1;

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;
    assign w_b_eff  = sub ? ~b : b;
    assign w_cin    = sub | c0;

    genvar k;
    generate
        for (k = 0; k < NSEG; k++) begin : g_st
            localparam int LO = k * SEG_W;
            // Operand bits entering this stage: only the segments not yet added.
            localparam int IW = WIDTH - LO;

            logic [IW-1:0]         w_a;
            logic [IW-1:0]         w_b;
            logic                  w_ci;
            logic                  w_vi;
            logic [SEG_W-1:0]      w_seg;
            logic                  w_co;
            logic [LO+SEG_W-1:0]   w_so;

            logic                  r_vld;
            logic                  r_c;
            logic [LO+SEG_W-1:0]   r_s;

            if (k == 0) begin : g_head
                assign w_a  = a;
                assign w_b  = w_b_eff;
                assign w_ci = w_cin;
                assign w_vi = in_valid;
                assign w_so = w_seg;
            end else begin : g_chain
                assign w_a  = g_st[k-1].g_fwd.r_a;
                assign w_b  = g_st[k-1].g_fwd.r_b;
                assign w_ci = g_st[k-1].r_c;
                assign w_vi = g_st[k-1].r_vld;
                assign w_so = {w_seg, g_st[k-1].r_s};
            end

            assign {w_co, w_seg} = {1'b0, w_a[SEG_W-1:0]} + {1'b0, w_b[SEG_W-1:0]}
                                 + {{SEG_W{1'b0}}, w_ci};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld <= 1'b0;
                    r_c   <= 1'b0;
                    r_s   <= '0;
                end else if (w_en) begin
                    r_vld <= w_vi;
                    r_c   <= w_co;
                    r_s   <= w_so;
                end
            end

            if (k < LAST) begin : g_fwd
                logic [IW-SEG_W-1:0] r_a;
                logic [IW-SEG_W-1:0] r_b;

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_a <= '0;
                        r_b <= '0;
                    end else if (w_en) begin
                        r_a <= w_a[IW-1:SEG_W];
                        r_b <= w_b[IW-1:SEG_W];
                    end
                end
            end else begin : g_out
                logic w_cmsb;
                logic r_sx;
                logic r_zero;

                // Carry into the MSB recovered from the MSB's own sum bit.
                assign w_cmsb = w_a[SEG_W-1] ^ w_b[SEG_W-1] ^ w_seg[SEG_W-1];

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_sx   <= 1'b0;
                        r_zero <= 1'b0;
                    end else if (w_en) begin
                        r_sx   <= w_cmsb ^ w_co;
                        r_zero <= (w_so == '0);
                    end
                end
            end
        end
    endgenerate

    assign out_valid = g_st[LAST].r_vld;
    assign s         = g_st[LAST].r_s;
    assign cout      = g_st[LAST].r_c;
    assign sx        = g_st[LAST].g_out.r_sx;
    assign zero      = g_st[LAST].g_out.r_zero;

endmodule
